// File: rtl/shift_sequencer.sv
// shift_sequencer: front-end sequencer for the rotate-left shift register.
// Bytes with a rotate amount arrive over valid/ready and wait in a small FIFO.
// Each byte produces one LOAD, ROT SHIFT pulses, then a DONE strobe in the
// cycle where the downstream register holds the rotated result.
// Build option: define SHIFT_SEQ_CNT_EN to add the BYTE_CNT output, which
// counts DONE pulses.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int RW    = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_FLAG,
    input  logic [RW-1:0]    IN_ROT,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic             LOAD,
    output logic             SHIFT,
    output logic [WIDTH-1:0] DATA_IN,
    output logic             DATA_IN_VALID,
    output logic             BUSY,
    output logic             DONE
`ifdef SHIFT_SEQ_CNT_EN
    ,
    output logic [15:0]      BYTE_CNT
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_HOLD
    } state_t;

    state_t           state;
    logic [RW-1:0]    cur_rot;
    logic [RW-1:0]    cnt;

    logic [WIDTH-1:0] fifo_data [DEPTH];
    logic             fifo_flag [DEPTH];
    logic [RW-1:0]    fifo_rot  [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [RW-1:0]    rot_in;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign IN_READY = !full && !RST;
    assign push     = IN_VALID && IN_READY;
    assign pop      = (state == ST_IDLE) && !empty;
    assign BUSY     = (state != ST_IDLE) || !empty;

    // Reduce an out-of-range rotate amount modulo WIDTH (one subtract suffices)
    always_comb begin
        rot_in = IN_ROT;
        if ({1'b0, IN_ROT} >= (RW+1)'(WIDTH)) begin
            rot_in = IN_ROT - RW'(WIDTH);
        end
    end

    // FIFO storage: written on an accepted handshake
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_data[wr_ptr] <= IN_DATA;
            fifo_flag[wr_ptr] <= IN_FLAG;
            fifo_rot[wr_ptr]  <= rot_in;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sequencing FSM with registered LOAD/SHIFT/DONE/DATA_IN outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= ST_IDLE;
            cur_rot       <= '0;
            cnt           <= '0;
            LOAD          <= 1'b0;
            SHIFT         <= 1'b0;
            DONE          <= 1'b0;
            DATA_IN       <= '0;
            DATA_IN_VALID <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        // Head goes straight into the output registers so LOAD
                        // and DATA_IN appear together in the next cycle.
                        cur_rot       <= fifo_rot[rd_ptr];
                        DATA_IN       <= fifo_data[rd_ptr];
                        DATA_IN_VALID <= fifo_flag[rd_ptr];
                        LOAD          <= 1'b1;
                        state         <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    LOAD <= 1'b0;
                    cnt  <= cur_rot;
                    if (cur_rot == '0) begin
                        DONE  <= 1'b1;
                        state <= ST_HOLD;
                    end else begin
                        SHIFT <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == RW'(1)) begin
                        SHIFT <= 1'b0;
                        DONE  <= 1'b1;
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    DONE  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    LOAD  <= 1'b0;
                    SHIFT <= 1'b0;
                    DONE  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SHIFT_SEQ_CNT_EN
    logic [15:0] byte_cnt;

    // Count completed bytes; wraps naturally at 16 bits
    always_ff @(posedge CLK) begin
        if (RST) begin
            byte_cnt <= '0;
        end else if (DONE) begin
            byte_cnt <= byte_cnt + 16'd1;
        end
    end

    assign BYTE_CNT = byte_cnt;
`endif

endmodule
